hazard3_clint_nharts: RTL and testbench

Parametrised machine-timer and software-interrupt block (CLINT-style) for the Hazard3 example SoC. It sits on the 32-bit APB peripheral bus. It provides one shared 64-bit `mtime`, and per-hart `msip` and 64-bit `mtimecmp` for `N_HARTS` harts. It also adds a counter enable, a debug-stop mode, an NRZ tick synchroniser, a fixed one-wait-state APB handshake, and error reporting on unmapped accesses.

---
 rtl/hazard3_clint_nharts_if.sv | 22 ++
 rtl/hazard3_clint_nharts.sv | 197 +++++++++++++++++++
 tb/tb_hazard3_clint_nharts.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_clint_nharts_if.sv
// APB3 slave-side bundle for the Hazard3 CLINT: address/control/data towards the
// block, and registered read data, ready and error flag back to the bus master.
interface hazard3_clint_nharts_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/hazard3_clint_nharts.sv
// CLINT-style timer and software-interrupt block: shared 64-bit mtime, per-hart
// msip and mtimecmp, counter enable, debug stop, optional NRZ tick input.
module hazard3_clint_nharts #(
  parameter int N_HARTS     = 2,
  parameter bit TICK_IS_NRZ = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard3_clint_nharts_if.slave apb,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t state;
  state_t state_next;

  logic [13:0]        word;
  logic [N_HARTS-1:0] hit_msip;
  logic [N_HARTS-1:0] hit_cmp_lo;
  logic [N_HARTS-1:0] hit_cmp_hi;
  logic               hit_mtime_lo;
  logic               hit_mtime_hi;
  logic               hit_ctrl;
  logic               mapped;
  logic [31:0]        rdata_mux;
  logic               wr_commit;
  logic               unused_addr;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp [N_HARTS];
  logic [N_HARTS-1:0] msip;
  logic [N_HARTS-1:0] timer_irq_q;
  logic               ctrl_en;
  logic               ctrl_dbgstop;
  logic               tick_evt;
  logic               inc;

  logic [31:0]        prdata_q;
  logic               pready_q;
  logic               pslverr_q;

  assign word        = apb.paddr[15:2];
  assign unused_addr = ^apb.paddr[1:0];

  // Address decode: one-hot hit vectors, so hart indices >= N_HARTS fall out as unmapped
  always_comb begin
    hit_msip     = '0;
    hit_cmp_lo   = '0;
    hit_cmp_hi   = '0;
    hit_mtime_lo = (word == 14'h040);
    hit_mtime_hi = (word == 14'h041);
    hit_ctrl     = (word == 14'h042);
    for (int h = 0; h < N_HARTS; h++) begin
      if (word == 14'(h))           hit_msip[h]   = 1'b1;
      if (word == 14'(128 + 2 * h)) hit_cmp_lo[h] = 1'b1;
      if (word == 14'(129 + 2 * h)) hit_cmp_hi[h] = 1'b1;
    end
  end

  assign mapped = (|hit_msip) | (|hit_cmp_lo) | (|hit_cmp_hi) |
                  hit_mtime_lo | hit_mtime_hi | hit_ctrl;

  always_comb begin
    rdata_mux = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (hit_msip[h])   rdata_mux = {31'b0, msip[h]};
      if (hit_cmp_lo[h]) rdata_mux = mtimecmp[h][31:0];
      if (hit_cmp_hi[h]) rdata_mux = mtimecmp[h][63:32];
    end
    if (hit_mtime_lo) rdata_mux = mtime[31:0];
    if (hit_mtime_hi) rdata_mux = mtime[63:32];
    if (hit_ctrl)     rdata_mux = {30'b0, ctrl_dbgstop, ctrl_en};
  end

  // APB handshake: fixed one wait state, ACK always lasts exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (apb.psel && apb.penable) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Response is captured on entry to ACK; reads therefore see the pre-ACK snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (state == S_IDLE && state_next == S_ACK) begin
      pready_q  <= 1'b1;
      prdata_q  <= (apb.pwrite || !mapped) ? 32'h0 : rdata_mux;
      pslverr_q <= !mapped;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;

  // A master that dropped psel/penable before the ACK edge gets no write
  assign wr_commit = (state == S_ACK) && apb.psel && apb.penable && apb.pwrite;

  generate
    if (TICK_IS_NRZ) begin : g_tick_nrz
      logic sync1;
      logic sync2;
      logic sync3;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          sync3 <= 1'b0;
        end else begin
          sync1 <= tick;
          sync2 <= sync1;
          sync3 <= sync2;
        end
      end
      assign tick_evt = sync2 ^ sync3;
    end else begin : g_tick_level
      assign tick_evt = tick;
    end
  endgenerate

  assign inc = tick_evt && ctrl_en && !(dbg_halt && ctrl_dbgstop);

  // A bus write to either half wins over the increment and blocks the carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_commit && hit_mtime_lo) begin
      mtime[31:0] <= apb.pwdata;
    end else if (wr_commit && hit_mtime_hi) begin
      mtime[63:32] <= apb.pwdata;
    end else if (inc) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en      <= 1'b1;
      ctrl_dbgstop <= 1'b1;
    end else if (wr_commit && hit_ctrl) begin
      ctrl_en      <= apb.pwdata[0];
      ctrl_dbgstop <= apb.pwdata[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip <= '0;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp[h] <= '1;
      end
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (wr_commit && hit_msip[h])   msip[h]            <= apb.pwdata[0];
        if (wr_commit && hit_cmp_lo[h]) mtimecmp[h][31:0]  <= apb.pwdata;
        if (wr_commit && hit_cmp_hi[h]) mtimecmp[h][63:32] <= apb.pwdata;
      end
    end
  end

  // Registered unsigned compare: interrupt follows mtime/mtimecmp by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_irq_q <= '0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        timer_irq_q[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  assign soft_irq  = msip;
  assign timer_irq = timer_irq_q;

endmodule

// File: tb/tb_hazard3_clint_nharts.sv
// Bench for hazard3_clint_nharts: a level-tick and an NRZ-tick instance share one
// APB stimulus stream; bus responses are checked against a queue of expectations.
module tb_hazard3_clint_nharts;
  localparam int NH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_halt = 1'b0;
  logic tick0 = 1'b0;
  logic tick1 = 1'b0;
  logic [NH-1:0] soft0, soft1, tirq0, tirq1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_soft;
  } op_t;

  exp_t exp_q[$];

  hazard3_clint_nharts_if bus0();
  hazard3_clint_nharts_if bus1();

  assign bus1.paddr   = bus0.paddr;
  assign bus1.psel    = bus0.psel;
  assign bus1.penable = bus0.penable;
  assign bus1.pwrite  = bus0.pwrite;
  assign bus1.pwdata  = bus0.pwdata;

  hazard3_clint_nharts #(.N_HARTS(NH), .TICK_IS_NRZ(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .apb(bus0), .dbg_halt(dbg_halt),
    .tick(tick0), .soft_irq(soft0), .timer_irq(tirq0)
  );

  hazard3_clint_nharts #(.N_HARTS(NH), .TICK_IS_NRZ(1'b1)) u_nrz (
    .clk(clk), .rst_n(rst_n), .apb(bus1), .dbg_halt(dbg_halt),
    .tick(tick1), .soft_irq(soft1), .timer_irq(tirq1)
  );

  always #5 clk = ~clk;

  // One APB transfer; returns the selected instance's response and the number of
  // cycles from penable to pready.
  task automatic apb(input int d, input bit wr, input logic [15:0] addr,
                     input logic [31:0] wdata, input bit tog1,
                     output logic [31:0] rdata, output logic err, output int lat);
    logic rdy;
    @(posedge clk); #1;
    bus0.psel = 1'b1; bus0.penable = 1'b0; bus0.pwrite = wr;
    bus0.paddr = addr; bus0.pwdata = wdata;
    if (tog1) tick1 = ~tick1;
    @(posedge clk); #1;
    bus0.penable = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = (d == 1) ? bus1.pready : bus0.pready;
    end while (!rdy && lat < 8);
    rdata = (d == 1) ? bus1.prdata : bus0.prdata;
    err   = (d == 1) ? bus1.pslverr : bus0.pslverr;
    if (!rdy) begin
      n_cmp++; n_fail++;
      $display("FAIL apb_timeout addr=%h: pready stayed 0, expected 1 within 8 cycles", addr);
    end
    @(posedge clk); #1;
    bus0.psel = 1'b0; bus0.penable = 1'b0; bus0.pwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat; exp_t e;
    bus0.psel = 0; bus0.penable = 0; bus0.pwrite = 0; bus0.paddr = '0; bus0.pwdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus0.prdata, bus0.pready, bus0.pslverr, soft0, tirq0, soft1, tirq1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b pslverr=%b soft=%b tirq=%b, expected all 0",
               bus0.prdata, bus0.pready, bus0.pslverr, soft0, tirq0);
    end
    rst_n = 1'b1;
    exp_q.push_back('{32'hFFFF_FFFF, 1'b0, 1'b1});
    apb(0, 1'b0, 16'h0204, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || er !== e.err) begin
      n_fail++;
      $display("FAIL reset_mtimecmph0: got %h err=%b, expected %h err=%b", rd, er, e.data, e.err);
    end
    n_cmp++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL apb_latency: got %0d wait cycles, expected 1", lat);
    end
    exp_q.push_back('{32'h3, 1'b0, 1'b1});
    apb(0, 1'b0, 16'h0108, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || er !== e.err) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h err=%b, expected %h err=%b", rd, er, e.data, e.err);
    end
    tick0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (tirq0 !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_no_timer_irq cycle %0d: got %b, expected 00", i, tirq0);
      end
    end
    tick0 = 1'b0;
  endtask

  task automatic test_timer_irq();
    logic [31:0] rd; logic er; int lat; exp_t e; op_t ops [6];
    ops = '{'{1'b1, 16'h0100, 32'd0,  32'd0,  1'b0, 2'b00},
            '{1'b1, 16'h0104, 32'd0,  32'd0,  1'b0, 2'b00},
            '{1'b1, 16'h0208, 32'd20, 32'd0,  1'b0, 2'b00},
            '{1'b1, 16'h020C, 32'd0,  32'd0,  1'b0, 2'b00},
            '{1'b0, 16'h0208, 32'd0,  32'd20, 1'b0, 2'b00},
            '{1'b0, 16'h0100, 32'd0,  32'd0,  1'b0, 2'b00}};
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].exp_data, ops[i].exp_err, !ops[i].wr});
      apb(0, ops[i].wr, ops[i].addr, ops[i].wdata, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (er !== e.err || (e.chk && rd !== e.data)) begin
        n_fail++;
        $display("FAIL timer_setup op%0d addr=%h: got %h err=%b, expected %h err=%b",
                 i, ops[i].addr, rd, er, e.data, e.err);
      end
    end
    tick0 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (tirq0 !== {(k >= 21), 1'b0}) begin
        n_fail++;
        $display("FAIL timer_irq after %0d ticks: got %b, expected %b", k, tirq0, {(k >= 21), 1'b0});
      end
    end
    tick0 = 1'b0;
    exp_q.push_back('{32'd24, 1'b0, 1'b1});
    apb(0, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || er !== e.err) begin
      n_fail++;
      $display("FAIL timer_mtime_count: got %h err=%b, expected %h err=%b", rd, er, e.data, e.err);
    end
  endtask

  task automatic test_irq_clear();
    logic [31:0] rd; logic er; int lat;
    apb(0, 1'b1, 16'h020C, 32'd1, 1'b0, rd, er, lat);
    n_cmp++;
    if (tirq0[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_clear_commit_cycle: got %b, expected 1", tirq0[1]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tirq0[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear_next_cycle: got %b, expected 0", tirq0[1]);
    end
  endtask

  task automatic test_soft_irq();
    logic [31:0] rd; logic er; int lat; exp_t e; op_t ops [8];
    ops = '{'{1'b1, 16'h0004, 32'hFFFF_FFFE, 32'd0, 1'b0, 2'b00},
            '{1'b1, 16'h0004, 32'h0000_0001, 32'd0, 1'b0, 2'b10},
            '{1'b0, 16'h0004, 32'h0,         32'd1, 1'b0, 2'b10},
            '{1'b0, 16'h0000, 32'h0,         32'd0, 1'b0, 2'b10},
            '{1'b1, 16'h0008, 32'h0000_0001, 32'd0, 1'b1, 2'b10},
            '{1'b0, 16'h0008, 32'h0,         32'd0, 1'b1, 2'b10},
            '{1'b0, 16'h010C, 32'h0,         32'd0, 1'b1, 2'b10},
            '{1'b1, 16'h0210, 32'h0,         32'd0, 1'b1, 2'b10}};
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].exp_data, ops[i].exp_err, !ops[i].wr});
      apb(0, ops[i].wr, ops[i].addr, ops[i].wdata, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (er !== e.err || (e.chk && rd !== e.data)) begin
        n_fail++;
        $display("FAIL soft_bus op%0d addr=%h: got %h err=%b, expected %h err=%b",
                 i, ops[i].addr, rd, er, e.data, e.err);
      end
      n_cmp++;
      if (soft0 !== ops[i].exp_soft) begin
        n_fail++;
        $display("FAIL soft_irq op%0d: got %b, expected %b", i, soft0, ops[i].exp_soft);
      end
    end
  endtask

  task automatic test_dbg_stop();
    logic [31:0] rd; logic er; int lat; exp_t e;
    logic [31:0] ctrl_v [3];
    logic [31:0] exp_mt [3];
    ctrl_v = '{32'h3, 32'h1, 32'h0};
    exp_mt = '{32'd0, 32'd10, 32'd10};
    apb(0, 1'b1, 16'h0100, 32'd0, 1'b0, rd, er, lat);
    apb(0, 1'b1, 16'h0104, 32'd0, 1'b0, rd, er, lat);
    for (int m = 0; m < 3; m++) begin
      apb(0, 1'b1, 16'h0108, ctrl_v[m], 1'b0, rd, er, lat);
      tick0 = 1'b1;
      dbg_halt = (m != 2);
      repeat (5) @(posedge clk);
      #1 dbg_halt = 1'b1;
      repeat (5) @(posedge clk);
      #1 tick0 = 1'b0; dbg_halt = 1'b0;
      exp_q.push_back('{exp_mt[m], 1'b0, 1'b1});
      apb(0, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.data || er !== e.err) begin
        n_fail++;
        $display("FAIL dbg_stop ctrl=%h mtime: got %h err=%b, expected %h err=%b",
                 ctrl_v[m], rd, er, e.data, e.err);
      end
      exp_q.push_back('{ctrl_v[m], 1'b0, 1'b1});
      apb(0, 1'b0, 16'h0108, 32'h0, 1'b0, rd, er, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.data) begin
        n_fail++;
        $display("FAIL dbg_stop ctrl readback: got %h, expected %h", rd, e.data);
      end
    end
  endtask

  task automatic test_nrz_wrap();
    logic [31:0] rd; logic er; int lat; exp_t e;
    apb(1, 1'b1, 16'h0108, 32'h3, 1'b0, rd, er, lat);
    apb(1, 1'b1, 16'h0100, 32'd0, 1'b0, rd, er, lat);
    apb(1, 1'b1, 16'h0104, 32'd0, 1'b0, rd, er, lat);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 tick1 = ~tick1;
      repeat (3) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    exp_q.push_back('{32'd7, 1'b0, 1'b1});
    exp_q.push_back('{32'd0, 1'b0, 1'b1});
    apb(1, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || er !== e.err) begin
      n_fail++;
      $display("FAIL nrz_count mtime: got %h err=%b, expected %h err=%b", rd, er, e.data, e.err);
    end
    apb(1, 1'b0, 16'h0104, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data || er !== e.err) begin
      n_fail++;
      $display("FAIL nrz_count mtimeh: got %h err=%b, expected %h err=%b", rd, er, e.data, e.err);
    end
    apb(1, 1'b1, 16'h0100, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
    apb(1, 1'b1, 16'h0104, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
    exp_q.push_back('{32'hFFFF_FFFF, 1'b0, 1'b1});
    apb(1, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin
      n_fail++;
      $display("FAIL nrz_preload mtime: got %h, expected %h", rd, e.data);
    end
    @(posedge clk); #1 tick1 = ~tick1;
    repeat (4) @(posedge clk);
    exp_q.push_back('{32'd0, 1'b0, 1'b1});
    exp_q.push_back('{32'd0, 1'b0, 1'b1});
    apb(1, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin
      n_fail++;
      $display("FAIL wrap mtime: got %h, expected %h", rd, e.data);
    end
    apb(1, 1'b0, 16'h0104, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin
      n_fail++;
      $display("FAIL wrap mtimeh: got %h, expected %h", rd, e.data);
    end
    apb(1, 1'b1, 16'h0100, 32'h0000_1234, 1'b1, rd, er, lat);
    repeat (4) @(posedge clk);
    exp_q.push_back('{32'h0000_1234, 1'b0, 1'b1});
    apb(1, 1'b0, 16'h0100, 32'h0, 1'b0, rd, er, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.data) begin
      n_fail++;
      $display("FAIL write_vs_tick mtime: got %h, expected %h", rd, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_irq_clear();
    test_soft_irq();
    test_dbg_stop();
    test_nrz_wrap();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
